conv3x3_stream: RTL and testbench

- Parametrised successor to the fixed 320x240 RGB 3x3 `processing` filter.
- Accepts an unpadded raster pixel stream of WIDTH x HEIGHT pixels, each carrying CH channels of DW bits.
- Generates the zero border internally, applies a run-time-selectable 3x3 kernel per channel, and emits WIDTH x HEIGHT filtered pixels in raster order.
- Adds input back-pressure (iReady), a self-timed end-of-frame flush, and back-to-back frame support.

---
 rtl/conv3x3_stream_if.sv | 20 ++
 rtl/conv3x3_stream.sv | 198 +++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_if.sv
// conv3x3_stream_if: pixel stream bundle for conv3x3_stream.
//   iValid/iReady/iData : input pixel handshake (transfer on iValid && iReady)
//   iMode               : kernel select, sampled on a frame's first pixel
//   oValid/oData/oDone  : output pixel stream (no stall), oDone on last pixel
// master = pixel source / sink side, slave = the filter.
interface conv3x3_stream_if #(
  parameter int CH = 3,
  parameter int DW = 8
);
  logic              iValid;
  logic              iReady;
  logic [CH*DW-1:0]  iData;
  logic [1:0]        iMode;
  logic              oValid;
  logic [CH*DW-1:0]  oData;
  logic              oDone;

  modport master (output iValid, iData, iMode, input iReady, oValid, oData, oDone);
  modport slave  (input iValid, iData, iMode, output iReady, oValid, oData, oDone);
endinterface

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 filter over a WIDTH x HEIGHT raster, CH
// independent DW-bit channels, zero border generated internally.
//   clk, reset : rising-edge clock, async active-high reset
//   s (slave)  : input handshake + mode, output valid/data/done
// Pipeline: step (transfer or flush cycle) loads the window; the next cycle
// computes the kernel; result is registered, so oValid trails its window
// step by two cycles.

// One channel of the kernel datapath; taps arrive already border-masked.
module conv3x3_lane #(
  parameter int DW = 8
) (
  input  logic [2:0][2:0][DW-1:0] tap,   // [row top..bottom][col left..right]
  input  logic [1:0]              mode,
  output logic [DW-1:0]           res
);
  localparam int AW = DW + 4;
  logic [AW-1:0] gsum;
  logic [AW-1:0] ssum;   // two's complement sharpen accumulator

  always_comb begin
    gsum = AW'(tap[0][0]) + AW'(tap[0][2]) + AW'(tap[2][0]) + AW'(tap[2][2])
         + (AW'(tap[0][1]) << 1) + (AW'(tap[1][0]) << 1)
         + (AW'(tap[1][2]) << 1) + (AW'(tap[2][1]) << 1)
         + (AW'(tap[1][1]) << 2);
    ssum = (AW'(tap[1][1]) << 2) + AW'(tap[1][1])
         - AW'(tap[0][1]) - AW'(tap[1][0]) - AW'(tap[1][2]) - AW'(tap[2][1]);
    res = tap[1][1];
    case (mode)
      2'd1: res = DW'(gsum >> 4);
      2'd2: begin
        if (ssum[AW-1])             res = '0;
        else if (|ssum[AW-2:DW])    res = '1;
        else                        res = ssum[DW-1:0];
      end
      default: res = tap[1][1];
    endcase
  end
endmodule

module conv3x3_stream #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int CH     = 3,
  parameter int DW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  conv3x3_stream_if.slave s
);
  localparam int PW = CH * DW;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT + 2);   // input row runs past the frame during flush

  typedef enum logic [1:0] {ACCEPT, FLUSH, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            in_c_q, in_c_d, out_c_q, out_c_d;
  logic [RW-1:0]            in_r_q, in_r_d, out_r_q, out_r_d;
  logic [1:0]               mode_q, mode_d;
  logic [2:0][2:0][PW-1:0]  win_q, win_d;
  logic [3:0]               bnd_q, bnd_d;   // {top, bottom, left, right} tap masks
  logic [1:0]               vld_pipe_q, vld_pipe_d;
  logic [1:0]               last_pipe_q, last_pipe_d;
  logic [PW-1:0]            odata_q, odata_d;

  // Not reset: border masking keeps stale contents out of every output.
  logic [PW-1:0]            lb0_q [WIDTH];   // row in_r-2
  logic [PW-1:0]            lb1_q [WIDTH];   // row in_r-1

  logic [PW-1:0]            lb0_rd, lb1_rd, pix;
  logic                     step, win_vld, flush_last, in_last, out_last;
  logic [CH-1:0][DW-1:0]    lane_res;

  assign step       = (state_q == ACCEPT && s.iValid) || state_q == FLUSH;
  assign pix        = (state_q == ACCEPT) ? s.iData : '0;
  assign lb0_rd     = lb0_q[in_c_q];
  assign lb1_rd     = lb1_q[in_c_q];
  assign in_last    = in_r_q == RW'(HEIGHT - 1) && in_c_q == CW'(WIDTH - 1);
  assign flush_last = in_r_q == RW'(HEIGHT + 1);
  assign out_last   = out_r_q == RW'(HEIGHT - 1) && out_c_q == CW'(WIDTH - 1);
  // Window is centred on a real pixel once WIDTH+1 steps have been taken.
  assign win_vld    = in_r_q >= RW'(2) || (in_r_q == RW'(1) && in_c_q != '0);

  assign s.iReady = (state_q == ACCEPT);
  assign s.oValid = vld_pipe_q[1];
  assign s.oData  = odata_q;
  assign s.oDone  = last_pipe_q[1];

  always_comb begin
    state_d     = state_q;
    in_c_d      = in_c_q;
    in_r_d      = in_r_q;
    out_c_d     = out_c_q;
    out_r_d     = out_r_q;
    mode_d      = mode_q;
    win_d       = win_q;
    bnd_d       = bnd_q;
    vld_pipe_d  = {vld_pipe_q[0], 1'b0};
    last_pipe_d = {last_pipe_q[0], 1'b0};
    odata_d     = vld_pipe_q[0] ? PW'(lane_res) : odata_q;

    if (step) begin
      if (flush_last) begin
        in_c_d = '0;
        in_r_d = '0;
      end else if (in_c_q == CW'(WIDTH - 1)) begin
        in_c_d = '0;
        in_r_d = in_r_q + RW'(1);
      end else begin
        in_c_d = in_c_q + CW'(1);
      end

      if (state_q == ACCEPT && in_r_q == '0 && in_c_q == '0) mode_d = s.iMode;

      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb0_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = pix;

      if (win_vld) begin
        vld_pipe_d[0]  = 1'b1;
        last_pipe_d[0] = out_last;
        bnd_d = {out_r_q == '0, out_r_q == RW'(HEIGHT - 1),
                 out_c_q == '0, out_c_q == CW'(WIDTH - 1)};
        if (out_last) begin
          out_c_d = '0;
          out_r_d = '0;
        end else if (out_c_q == CW'(WIDTH - 1)) begin
          out_c_d = '0;
          out_r_d = out_r_q + RW'(1);
        end else begin
          out_c_d = out_c_q + CW'(1);
        end
      end
    end

    case (state_q)
      ACCEPT:  if (step && in_last) state_d = FLUSH;
      FLUSH:   if (flush_last)      state_d = DRAIN;
      DRAIN:   if (last_pipe_q[1])  state_d = ACCEPT;
      default:                      state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCEPT;
      in_c_q      <= '0;
      in_r_q      <= '0;
      out_c_q     <= '0;
      out_r_q     <= '0;
      mode_q      <= '0;
      win_q       <= '0;
      bnd_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      odata_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_c_q      <= in_c_d;
      in_r_q      <= in_r_d;
      out_c_q     <= out_c_d;
      out_r_q     <= out_r_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      bnd_q       <= bnd_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      odata_q     <= odata_d;
    end
  end

  // Column-wise shift: row in_r-1 moves down to lb0, the new pixel into lb1.
  always_ff @(posedge clk) begin
    if (step) begin
      lb0_q[in_c_q] <= lb1_rd;
      lb1_q[in_c_q] <= pix;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic [2:0][2:0][DW-1:0] tap;
    always_comb begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          tap[i][j] = ((i == 0 && bnd_q[3]) || (i == 2 && bnd_q[2]) ||
                       (j == 0 && bnd_q[1]) || (j == 2 && bnd_q[0]))
                      ? '0 : win_q[i][j][k*DW +: DW];
        end
      end
    end
    conv3x3_lane #(.DW(DW)) u_lane (.tap(tap), .mode(mode_q), .res(lane_res[k]));
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: randomized self-checking bench for conv3x3_stream on a
// small frame; expected pixels come from a zero-padded 3x3 arithmetic model.
module tb_conv3x3_stream;
  localparam int W = 8, H = 6, CH = 3, DW = 8, PW = CH * DW, NPIX = W * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv3x3_stream_if #(.CH(CH), .DW(DW)) s();
  conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .CH(CH), .DW(DW))
    dut (.clk(clk), .reset(reset), .s(s));

  int checks = 0, errors = 0, cyc = 0;
  logic [PW-1:0] fin [2*NPIX];
  logic [PW-1:0] out_q [$];
  int ov_cyc [$], acc_cyc [$], done_cyc [$], done_pos [$];
  int done_cnt = 0, ready_low = 0, done_no_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (s.oValid) begin out_q.push_back(s.oData); ov_cyc.push_back(cyc); end
      if (s.oDone) begin
        done_cnt++; done_cyc.push_back(cyc); done_pos.push_back(out_q.size());
        if (!s.oValid) done_no_valid++;
      end
      if (!s.iReady) ready_low++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int px(int base, int r, int c, int k);
    logic [PW-1:0] w;
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    w = fin[base + r*W + c];
    return int'(w[k*DW +: DW]);
  endfunction

  function automatic logic [PW-1:0] model(int base, int p, int mode);
    int r, c, a;
    logic [PW-1:0] o;
    r = p / W; c = p % W; o = '0;
    for (int k = 0; k < CH; k++) begin
      case (mode)
        1: a = (px(base,r-1,c-1,k) + 2*px(base,r-1,c,k) + px(base,r-1,c+1,k)
              + 2*px(base,r,c-1,k) + 4*px(base,r,c,k) + 2*px(base,r,c+1,k)
              + px(base,r+1,c-1,k) + 2*px(base,r+1,c,k) + px(base,r+1,c+1,k)) / 16;
        2: begin
          a = 5*px(base,r,c,k) - px(base,r-1,c,k) - px(base,r+1,c,k)
            - px(base,r,c-1,k) - px(base,r,c+1,k);
          if (a < 0) a = 0;
          if (a > (1 << DW) - 1) a = (1 << DW) - 1;
        end
        default: a = px(base,r,c,k);
      endcase
      o[k*DW +: DW] = a[DW-1:0];
    end
    return o;
  endfunction

  function automatic logic [PW-1:0] rep(int v);
    logic [PW-1:0] o;
    for (int k = 0; k < CH; k++) o[k*DW +: DW] = v[DW-1:0];
    return o;
  endfunction

  // ---------------- drivers / helpers ----------------
  task automatic clear_obs();
    out_q.delete(); ov_cyc.delete(); acc_cyc.delete();
    done_cyc.delete(); done_pos.delete();
    done_cnt = 0; ready_low = 0; done_no_valid = 0;
  endtask

  task automatic send_frame(input int base, input int mode, input int gap,
                            input int toggle_at, input int npx);
    int idx, guard;
    idx = 0; guard = 0;
    while (idx < npx && guard < 20000) begin
      @(negedge clk); guard++;
      if (gap > 0 && $urandom_range(99) < gap) begin
        s.iValid = 1'b0; s.iData = PW'($urandom);
      end else begin
        s.iValid = 1'b1;
        s.iData  = fin[base + idx];
        s.iMode  = (toggle_at >= 0 && idx >= toggle_at) ? 2'd2 : 2'(mode);
        if (s.iReady) begin acc_cyc.push_back(cyc); idx++; end
      end
    end
    if (idx < npx) begin
      checks++; errors++;
      $display("FAIL send_frame: sent %0d pixels, required %0d", idx, npx);
    end
  endtask

  task automatic wait_done(input int n, input bit junk);
    int seen, guard, junk_acc;
    seen = 0; guard = 0; junk_acc = 0;
    while (seen < n && guard < 5000) begin
      @(negedge clk); guard++;
      if (s.oDone) begin seen++; s.iValid = 1'b0; end
      else if (junk) begin
        s.iValid = 1'b1; s.iData = PW'($urandom);
        if (s.iReady) junk_acc++;
      end else s.iValid = 1'b0;
    end
    s.iValid = 1'b0;
    checks++;
    if (seen < n) begin errors++; $display("FAIL wait_done: saw %0d oDone, required %0d", seen, n); end
    checks++;
    if (junk_acc != 0) begin errors++; $display("FAIL flush_ignore: %0d junk accepts, required 0", junk_acc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input int base, input int mode, input int off, input string name);
    logic [PW-1:0] e;
    checks++;
    if (out_q.size() < off + NPIX) begin
      errors++;
      $display("FAIL %s count: got %0d outputs, required %0d", name, out_q.size(), off + NPIX);
      return;
    end
    for (int p = 0; p < NPIX; p++) begin
      e = model(base, p, mode);
      checks++;
      if (out_q[off + p] !== e) begin
        errors++;
        $display("FAIL %s pix %0d: got %h required %h", name, p, out_q[off + p], e);
      end
    end
  endtask

  task automatic check_px(input int p, input int v, input string name);
    checks++;
    if (p >= out_q.size()) begin
      errors++; $display("FAIL %s: output %0d missing", name, p);
    end else if (out_q[p] !== rep(v)) begin
      errors++; $display("FAIL %s: got %h required %h", name, out_q[p], rep(v));
    end
  endtask

  task automatic fill_rand(input int base);
    for (int i = 0; i < NPIX; i++) fin[base + i] = PW'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    s.iValid = 1'b0; s.iData = '0; s.iMode = 2'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (s.iReady !== 1'b1) begin errors++; $display("FAIL reset_iReady: got %b required 1", s.iReady); end
    if (s.oValid !== 1'b0) begin errors++; $display("FAIL reset_oValid: got %b required 0", s.oValid); end
    if (s.oData  !== '0)   begin errors++; $display("FAIL reset_oData: got %h required 0", s.oData); end
    if (s.oDone  !== 1'b0) begin errors++; $display("FAIL reset_oDone: got %b required 0", s.oDone); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bypass();
    for (int i = 0; i < NPIX; i++) fin[i] = rep(i);
    clear_obs();
    send_frame(0, 0, 0, -1, NPIX);
    wait_done(1, 1'b0);
    check_frame(0, 0, 0, "bypass");
    checks++;
    if (out_q.size() != NPIX) begin errors++; $display("FAIL bypass_count: got %0d required %0d", out_q.size(), NPIX); end
    checks++;
    if (ov_cyc.size() < 1 || acc_cyc.size() < W + 2) begin errors++; $display("FAIL bypass_latency: missing events"); end
    else if (ov_cyc[0] - acc_cyc[W+1] != 2) begin
      errors++; $display("FAIL bypass_latency: got %0d required 2", ov_cyc[0] - acc_cyc[W+1]);
    end
    checks++;
    if (done_cnt != 1 || done_pos.size() < 1 || done_pos[0] != NPIX || done_no_valid != 0) begin
      errors++; $display("FAIL bypass_done: count %0d, pos %0d, required 1 at %0d with oValid",
                         done_cnt, (done_pos.size() > 0) ? done_pos[0] : -1, NPIX);
    end
    checks++;
    if (ready_low != W + 3) begin errors++; $display("FAIL bypass_ready_low: got %0d required %0d", ready_low, W + 3); end
    checks++;
    if (done_cyc.size() < 1 || acc_cyc.size() < 1 || done_cyc[0] - acc_cyc[0] != NPIX + W + 2) begin
      errors++; $display("FAIL bypass_frame_len: got %0d required %0d",
                         (done_cyc.size() > 0 && acc_cyc.size() > 0) ? done_cyc[0] - acc_cyc[0] : -1, NPIX + W + 2);
    end
  endtask

  task automatic test_gaussian();
    for (int i = 0; i < NPIX; i++) fin[i] = rep(100);
    clear_obs();
    send_frame(0, 1, 0, -1, NPIX);
    wait_done(1, 1'b0);
    check_frame(0, 1, 0, "gauss_const");
    check_px(0, 56, "gauss_corner");
    check_px(5, 75, "gauss_top_edge");
    check_px(W + 1, 100, "gauss_interior");
    fill_rand(0);
    clear_obs();
    send_frame(0, 1, 0, -1, NPIX);
    wait_done(1, 1'b0);
    check_frame(0, 1, 0, "gauss_rand");
  endtask

  task automatic test_sharpen();
    for (int i = 0; i < NPIX; i++) fin[i] = rep(200);
    clear_obs();
    send_frame(0, 2, 0, -1, NPIX);
    wait_done(1, 1'b0);
    check_frame(0, 2, 0, "sharp_const");
    check_px(0, 255, "sharp_corner");
    check_px(W + 1, 200, "sharp_interior");
    for (int i = 0; i < NPIX; i++) fin[i] = '0;
    fin[W + 1] = rep(255);
    clear_obs();
    send_frame(0, 2, 0, -1, NPIX);
    wait_done(1, 1'b0);
    check_px(W + 1, 255, "sharp_impulse_centre");
    check_px(1, 0, "sharp_impulse_up");
    check_px(W, 0, "sharp_impulse_left");
    fill_rand(0);
    clear_obs();
    send_frame(0, 2, 0, -1, NPIX);
    wait_done(1, 1'b0);
    check_frame(0, 2, 0, "sharp_rand");
    clear_obs();
    send_frame(0, 3, 0, -1, NPIX);
    wait_done(1, 1'b0);
    check_frame(0, 3, 0, "mode3_bypass");
  endtask

  task automatic test_gaps();
    for (int i = 0; i < NPIX; i++) fin[i] = rep(i);
    clear_obs();
    send_frame(0, 0, 30, -1, NPIX);
    wait_done(1, 1'b1);
    check_frame(0, 0, 0, "gaps_bypass");
    checks++;
    if (out_q.size() != NPIX || done_cnt != 1) begin
      errors++; $display("FAIL gaps_count: got %0d outputs %0d done, required %0d and 1", out_q.size(), done_cnt, NPIX);
    end
  endtask

  task automatic test_reset_midframe();
    fill_rand(0);
    send_frame(0, 1, 0, -1, 20);
    @(negedge clk);
    s.iValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks += 3;
    if (s.oValid !== 1'b0) begin errors++; $display("FAIL midreset_oValid: got %b required 0", s.oValid); end
    if (s.oData  !== '0)   begin errors++; $display("FAIL midreset_oData: got %h required 0", s.oData); end
    if (s.iReady !== 1'b1) begin errors++; $display("FAIL midreset_iReady: got %b required 1", s.iReady); end
    reset = 1'b0;
    fill_rand(0);
    clear_obs();
    send_frame(0, 1, 0, 10, NPIX);   // iMode flips to sharpen mid-frame: must be ignored
    wait_done(1, 1'b0);
    check_frame(0, 1, 0, "midreset_gauss");
  endtask

  task automatic test_back_to_back();
    fill_rand(0);
    fill_rand(NPIX);
    clear_obs();
    send_frame(0, 1, 0, -1, NPIX);
    send_frame(NPIX, 1, 0, -1, NPIX);
    wait_done(1, 1'b0);
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL b2b_done: got %0d required 2", done_cnt); end
    check_frame(0, 1, 0, "b2b_frame0");
    check_frame(NPIX, 1, NPIX, "b2b_frame1");
    checks++;
    if (done_cyc.size() < 1 || acc_cyc.size() < NPIX + 1 || acc_cyc[NPIX] != done_cyc[0] + 1) begin
      errors++; $display("FAIL b2b_restart: frame1 first accept %0d required %0d",
                         (acc_cyc.size() > NPIX) ? acc_cyc[NPIX] : -1,
                         (done_cyc.size() > 0) ? done_cyc[0] + 1 : -1);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_gaussian();
    test_sharpen();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
